// File: rtl/super_sonic_tx_fmt.sv
// Ultrasonic distance TX formatter: latches a distance, converts it to BCD and streams
// "<P>=DDDcm\r\n" to the UART TX byte handshake. SUPER_SONIC_TX_ZERO_BLANK_EN blanks leading zeros.
module super_sonic_tx_fmt #(
    parameter logic [7:0] MSG_PREFIX = 8'h44
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       i_send,
    input  logic [8:0] i_dist,
    input  logic       i_dist_err,
    input  logic       i_tx_busy,
    input  logic       i_tx_done,
    output logic [7:0] o_tx_data,
    output logic       o_tx_start,
    output logic       o_busy,
    output logic       o_done
);

`ifdef SUPER_SONIC_TX_ZERO_BLANK_EN
    localparam bit ZeroBlank = 1'b1;
`else
    localparam bit ZeroBlank = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StConv, StLoad, StWait} state_e;

    state_e      state_q;
    logic [3:0]  idx_q;
    logic [3:0]  cnt_q;
    logic [8:0]  dist_q;
    logic        err_q;
    logic [11:0] bcd_q;
    logic [7:0]  tx_data_q;
    logic        tx_start_q;
    logic        busy_q;
    logic        done_q;

    logic [11:0] bcd_adj;
    logic [11:0] bcd_d;
    logic [7:0]  dig2, dig1, dig0;
    logic [7:0]  byte_sel;

    // Double-dabble step: correct each nibble >= 5 then shift in the next binary bit.
    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5)  bcd_adj[3:0]  = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5)  bcd_adj[7:4]  = bcd_q[7:4] + 4'd3;
        if (bcd_q[11:8] >= 4'd5) bcd_adj[11:8] = bcd_q[11:8] + 4'd3;
        bcd_d = {bcd_adj[10:0], dist_q[8]};
    end

    always_comb begin
        dig2 = {4'h3, bcd_q[11:8]};
        dig1 = {4'h3, bcd_q[7:4]};
        dig0 = {4'h3, bcd_q[3:0]};
        if (ZeroBlank && (bcd_q[11:8] == 4'd0)) begin
            dig2 = 8'h20;
            if (bcd_q[7:4] == 4'd0) dig1 = 8'h20;
        end
        if (err_q) begin
            dig2 = 8'h45;
            dig1 = 8'h52;
            dig0 = 8'h52;
        end
    end

    always_comb begin
        case (idx_q)
            4'd0:    byte_sel = MSG_PREFIX;
            4'd1:    byte_sel = 8'h3D;
            4'd2:    byte_sel = dig2;
            4'd3:    byte_sel = dig1;
            4'd4:    byte_sel = dig0;
            4'd5:    byte_sel = 8'h63;
            4'd6:    byte_sel = 8'h6D;
            4'd7:    byte_sel = 8'h0D;
            default: byte_sel = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            idx_q      <= 4'd0;
            cnt_q      <= 4'd0;
            dist_q     <= 9'd0;
            err_q      <= 1'b0;
            bcd_q      <= 12'd0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start && i_send) begin
                        dist_q  <= i_dist;
                        err_q   <= i_dist_err;
                        idx_q   <= 4'd0;
                        cnt_q   <= 4'd0;
                        bcd_q   <= 12'd0;
                        busy_q  <= 1'b1;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    bcd_q  <= bcd_d;
                    dist_q <= {dist_q[7:0], 1'b0};
                    cnt_q  <= cnt_q + 4'd1;
                    if (cnt_q == 4'd8) state_q <= StLoad;
                end
                StLoad: begin
                    if (!i_tx_busy) begin
                        tx_data_q  <= byte_sel;
                        tx_start_q <= 1'b1;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (i_tx_done) begin
                        if (idx_q == 4'd8) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 4'd1;
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_done     = done_q;

endmodule
